// File: rtl/vgacpu_pkg.sv
// Shared types and default widths for the VGA/CPU SRAM subsystem.
// Holds the read-owner tag carried down the arbiter pipeline, the default
// data/address widths used by inferred_sram, and the grant bit positions.
package vgacpu_pkg;

  localparam int unsigned SRAM_D_WIDTH = 8;
  localparam int unsigned SRAM_A_WIDTH = 8;

  // Bit positions inside the one-hot grant / request vectors
  localparam int unsigned GNT_VGA = 0;
  localparam int unsigned GNT_CPU = 1;
  localparam int unsigned GNT_RAS = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_RAS  = 2'd3
  } owner_t;

  // Converts a one-hot grant vector into the owner tag of the winner
  function automatic owner_t gnt_to_owner(input logic [2:0] gnt);
    owner_t own;
    own = OWN_NONE;
    if (gnt[GNT_VGA])      own = OWN_VGA;
    else if (gnt[GNT_CPU]) own = OWN_CPU;
    else if (gnt[GNT_RAS]) own = OWN_RAS;
    return own;
  endfunction

endpackage

// File: rtl/vgacpu_sram_arb_pick.sv
// Combinational grant picker for the SRAM arbiter.
// Ports:
//   i_req  [2:0] requests {ras, cpu, vga}
//   i_ptr        tie-break pointer: 0 = CPU next, 1 = rasterizer next
//   o_gnt  [2:0] one-hot grants {ras, cpu, vga}
// VGA always wins; the pointer only decides CPU vs rasterizer contention.
module vgacpu_sram_arb_pick
  import vgacpu_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic       i_ptr,
  output logic [2:0] o_gnt
);

  always_comb begin
    o_gnt = 3'b000;
    if (i_req[GNT_VGA]) begin
      o_gnt[GNT_VGA] = 1'b1;
    end else if (i_req[GNT_CPU] && i_req[GNT_RAS]) begin
      if (i_ptr) o_gnt[GNT_RAS] = 1'b1;
      else       o_gnt[GNT_CPU] = 1'b1;
    end else if (i_req[GNT_CPU]) begin
      o_gnt[GNT_CPU] = 1'b1;
    end else if (i_req[GNT_RAS]) begin
      o_gnt[GNT_RAS] = 1'b1;
    end
  end

endmodule

// File: rtl/vgacpu_sram_arbiter.sv
// Shares the single-port SRAM between VGA scanout (read-only, top priority),
// the CPU and the rasterizer. One access per cycle; reads return 2 cycles
// after the accepting edge on the owner's rvalid/rdata.
// Ports:
//   clk, rst                      clock, async active-high reset
//   vga_req/addr -> vga_gnt       VGA read request and same-cycle grant
//   vga_rvalid/rdata              VGA read return
//   cpu_*/ras_*                   req/we/addr/wdata in, gnt/rvalid/rdata out
//   sram_addr/we/wdata            registered SRAM command
//   sram_rdata                    SRAM read data (one cycle after address)
// Build option: VGACPU_SRAM_ARB_ROUND_ROBIN_EN alternates CPU and rasterizer;
// without it the CPU always beats the rasterizer.
module vgacpu_sram_arbiter
  import vgacpu_pkg::*;
#(
  parameter int unsigned D_WIDTH = SRAM_D_WIDTH,
  parameter int unsigned A_WIDTH = SRAM_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vga_req,
  input  logic [A_WIDTH-1:0] vga_addr,
  output logic               vga_gnt,
  output logic               vga_rvalid,
  output logic [D_WIDTH-1:0] vga_rdata,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [A_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_wdata,
  output logic               cpu_gnt,
  output logic               cpu_rvalid,
  output logic [D_WIDTH-1:0] cpu_rdata,
  input  logic               ras_req,
  input  logic               ras_we,
  input  logic [A_WIDTH-1:0] ras_addr,
  input  logic [D_WIDTH-1:0] ras_wdata,
  output logic               ras_gnt,
  output logic               ras_rvalid,
  output logic [D_WIDTH-1:0] ras_rdata,
  output logic [A_WIDTH-1:0] sram_addr,
  output logic               sram_we,
  output logic [D_WIDTH-1:0] sram_wdata,
  input  logic [D_WIDTH-1:0] sram_rdata
);

  logic [2:0]         w_req;
  logic [2:0]         w_gnt;
  logic               w_ptr;
  logic [A_WIDTH-1:0] w_addr;
  logic               w_we;
  logic [D_WIDTH-1:0] w_wdata;

  logic [A_WIDTH-1:0] r_sram_addr;
  logic               r_sram_we;
  logic [D_WIDTH-1:0] r_sram_wdata;
  owner_t             r_tag1;
  owner_t             r_tag2;
  logic               r_vga_rvalid, r_cpu_rvalid, r_ras_rvalid;
  logic [D_WIDTH-1:0] r_vga_rdata, r_cpu_rdata, r_ras_rdata;

  // Requests are masked during reset so no grant can leak out
  assign w_req = rst ? 3'b000 : {ras_req, cpu_req, vga_req};

`ifdef VGACPU_SRAM_ARB_ROUND_ROBIN_EN
  logic r_rr_ptr;

  // After a CPU grant the rasterizer is next, and vice versa; VGA leaves it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_gnt[GNT_CPU] || w_gnt[GNT_RAS]) begin
      r_rr_ptr <= w_gnt[GNT_CPU];
    end
  end

  assign w_ptr = r_rr_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  vgacpu_sram_arb_pick u_pick (
    .i_req (w_req),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt)
  );

  assign vga_gnt = w_gnt[GNT_VGA];
  assign cpu_gnt = w_gnt[GNT_CPU];
  assign ras_gnt = w_gnt[GNT_RAS];

  // Winner command mux; VGA never writes and leaves wdata untouched
  always_comb begin
    w_addr  = r_sram_addr;
    w_we    = 1'b0;
    w_wdata = r_sram_wdata;
    if (w_gnt[GNT_VGA]) begin
      w_addr = vga_addr;
    end else if (w_gnt[GNT_CPU]) begin
      w_addr  = cpu_addr;
      w_we    = cpu_we;
      w_wdata = cpu_wdata;
    end else if (w_gnt[GNT_RAS]) begin
      w_addr  = ras_addr;
      w_we    = ras_we;
      w_wdata = ras_wdata;
    end
  end

  // Issue stage: SRAM command register plus owner tag for reads only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sram_addr  <= '0;
      r_sram_we    <= 1'b0;
      r_sram_wdata <= '0;
      r_tag1       <= OWN_NONE;
    end else if (|w_gnt) begin
      r_sram_addr  <= w_addr;
      r_sram_we    <= w_we;
      r_sram_wdata <= w_wdata;
      r_tag1       <= w_we ? OWN_NONE : gnt_to_owner(w_gnt);
    end else begin
      r_sram_we    <= 1'b0;
      r_tag1       <= OWN_NONE;
    end
  end

  // Return stage: tag follows the SRAM read latency, then steers rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag2       <= OWN_NONE;
      r_vga_rvalid <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_ras_rvalid <= 1'b0;
      r_vga_rdata  <= '0;
      r_cpu_rdata  <= '0;
      r_ras_rdata  <= '0;
    end else begin
      r_tag2       <= r_tag1;
      r_vga_rvalid <= (r_tag2 == OWN_VGA);
      r_cpu_rvalid <= (r_tag2 == OWN_CPU);
      r_ras_rvalid <= (r_tag2 == OWN_RAS);
      if (r_tag2 == OWN_VGA) r_vga_rdata <= sram_rdata;
      if (r_tag2 == OWN_CPU) r_cpu_rdata <= sram_rdata;
      if (r_tag2 == OWN_RAS) r_ras_rdata <= sram_rdata;
    end
  end

  assign sram_addr  = r_sram_addr;
  assign sram_we    = r_sram_we;
  assign sram_wdata = r_sram_wdata;
  assign vga_rvalid = r_vga_rvalid;
  assign cpu_rvalid = r_cpu_rvalid;
  assign ras_rvalid = r_ras_rvalid;
  assign vga_rdata  = r_vga_rdata;
  assign cpu_rdata  = r_cpu_rdata;
  assign ras_rdata  = r_ras_rdata;

endmodule

// File: tb/tb_vgacpu_sram_arbiter.sv
// Scoreboard bench for vgacpu_sram_arbiter with a behavioural SRAM and a
// reference model of priority, memory contents and return timing.
module tb_vgacpu_sram_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  logic          vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid, ras_gnt, ras_rvalid;
  logic [DW-1:0] vga_rdata, cpu_rdata, ras_rdata;
  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic [DW-1:0] sram_wdata, sram_rdata;

  logic [2:0] d_req;
  req_t       d_cur [3];
  logic [2:0] xfer_last;

  req_t stim_q [3][$];
  exp_t eq [3][$];

  int cyc = 0;
  int n_tot = 0;
  int n_pass = 0;

  vgacpu_sram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .vga_req(d_req[0]), .vga_addr(d_cur[0].addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(d_req[1]), .cpu_we(d_cur[1].we), .cpu_addr(d_cur[1].addr), .cpu_wdata(d_cur[1].wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ras_req(d_req[2]), .ras_we(d_cur[2].we), .ras_addr(d_cur[2].addr), .ras_wdata(d_cur[2].wdata),
    .ras_gnt(ras_gnt), .ras_rvalid(ras_rvalid), .ras_rdata(ras_rdata),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  function automatic logic [DW-1:0] pre(input int a);
    return 8'(a * 37 + 90);
  endfunction

  // Behavioural single-port SRAM with one-cycle read latency
  logic [DW-1:0] sram_mem [256];
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 256; a++) sram_mem[a] <= pre(a);
    end else begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      sram_rdata <= sram_mem[sram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Driver: presents queued requests, holding each until it was transferred
  initial begin
    d_req = 3'b000;
    for (int i = 0; i < 3; i++) d_cur[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (rst || xfer_last[i]) d_req[i] = 1'b0;
        if (!rst && !d_req[i] && stim_q[i].size() > 0) begin
          d_cur[i] = stim_q[i].pop_front();
          d_req[i] = 1'b1;
        end
      end
    end
  end

  // Reference model + monitor
  logic [DW-1:0] exp_mem [256];
  logic          m_ptr;        // 0: CPU next, 1: rasterizer next
  logic          exp_we_nxt;
  logic          exp_iss_nxt;
  logic [AW-1:0] exp_addr_nxt;
  logic [DW-1:0] exp_wd_nxt;
  logic [2:0]    gnt_v, rv_v, eg;
  logic [DW-1:0] rd_v [3];
  exp_t          e;
  int            w;
  req_t          r;

  assign gnt_v = {ras_gnt, cpu_gnt, vga_gnt};
  assign rv_v  = {ras_rvalid, cpu_rvalid, vga_rvalid};
  assign rd_v[0] = vga_rdata;
  assign rd_v[1] = cpu_rdata;
  assign rd_v[2] = ras_rdata;

  always @(negedge clk) begin
    if (preload) for (int a = 0; a < 256; a++) exp_mem[a] = pre(a);
    if (rst) begin
      chk("rst_gnt", 32'(gnt_v), 32'd0);
      chk("rst_rvalid", 32'(rv_v), 32'd0);
      chk("rst_sram_we", 32'(sram_we), 32'd0);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_sram_wdata", 32'(sram_wdata), 32'd0);
      chk("rst_rdata", 32'({vga_rdata, cpu_rdata, ras_rdata}), 32'd0);
      for (int i = 0; i < 3; i++) eq[i].delete();
      m_ptr = 1'b0; exp_we_nxt = 1'b0; exp_iss_nxt = 1'b0; xfer_last = 3'b000;
    end else begin
      // SRAM command produced by the previous cycle's transfer
      chk("sram_we", 32'(sram_we), 32'(exp_we_nxt));
      if (exp_iss_nxt) chk("sram_addr", 32'(sram_addr), 32'(exp_addr_nxt));
      if (exp_we_nxt)  chk("sram_wdata", 32'(sram_wdata), 32'(exp_wd_nxt));
      // Read returns
      for (int i = 0; i < 3; i++) begin
        if (rv_v[i]) begin
          if (eq[i].size() == 0) begin
            chk($sformatf("unexpected_rvalid%0d", i), 32'd1, 32'd0);
          end else begin
            e = eq[i].pop_front();
            chk($sformatf("rdata%0d", i), 32'(rd_v[i]), 32'(e.data));
            chk($sformatf("rvalid_cycle%0d", i), 32'(cyc), 32'(e.cyc));
          end
        end else if (eq[i].size() > 0 && eq[i][0].cyc <= cyc) begin
          e = eq[i].pop_front();
          chk($sformatf("missing_rvalid%0d", i), 32'd0, 32'd1);
        end
      end
      // Arbitration: VGA first, then CPU/rasterizer by policy
      eg = 3'b000;
      if (d_req[0])                 eg = 3'b001;
      else if (d_req[1] && d_req[2]) eg = m_ptr ? 3'b100 : 3'b010;
      else if (d_req[1])            eg = 3'b010;
      else if (d_req[2])            eg = 3'b100;
      chk("gnt", 32'(gnt_v), 32'(eg));
      xfer_last = eg;
      exp_we_nxt = 1'b0;
      exp_iss_nxt = 1'b0;
      if (eg != 3'b000) begin
        w = eg[0] ? 0 : (eg[1] ? 1 : 2);
        r = d_cur[w];
        exp_iss_nxt = 1'b1;
        exp_addr_nxt = r.addr;
        if (w != 0 && r.we) begin
          exp_mem[r.addr] = r.wdata;
          exp_we_nxt = 1'b1;
          exp_wd_nxt = r.wdata;
        end else begin
          // Accept edge follows this cycle; data appears two edges after it
          eq[w].push_back('{data: exp_mem[r.addr], cyc: cyc + 3});
        end
`ifdef VGACPU_SRAM_ARB_ROUND_ROBIN_EN
        if (w == 1) m_ptr = 1'b1;
        if (w == 2) m_ptr = 1'b0;
`endif
      end
    end
  end

  task automatic push(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t q;
    q.we = (i == 0) ? 1'b0 : we;
    q.addr = a;
    q.wdata = d;
    stim_q[i].push_back(q);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 600 && !ok; n++) begin
      @(negedge clk);
      #1;
      ok = (d_req == 3'b000) && (stim_q[0].size() == 0) && (stim_q[1].size() == 0) &&
           (stim_q[2].size() == 0) && (eq[0].size() == 0) && (eq[1].size() == 0) &&
           (eq[2].size() == 0);
    end
    if (!ok) chk({"timeout_", tag}, 32'd0, 32'd1);
  endtask

  initial begin
    bit seen;
    @(negedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;

    // CPU write then read of the same address
    push(1, 1'b1, 8'h20, 8'hA5);
    push(1, 1'b0, 8'h20, 8'h00);
    wait_idle("cpu_wr_rd");

    // VGA holds the bus for 4 cycles while CPU and rasterizer wait
    for (int k = 0; k < 4; k++) push(0, 1'b0, 8'(8'h40 + k), 8'h00);
    push(1, 1'b0, 8'h50, 8'h00);
    push(2, 1'b0, 8'h51, 8'h00);
    wait_idle("vga_prio");

    // CPU and rasterizer contend continuously
    for (int k = 0; k < 4; k++) begin
      push(1, 1'b0, 8'(8'h60 + k), 8'h00);
      push(2, 1'b1, 8'(8'h70 + k), 8'(8'hC0 + k));
    end
    wait_idle("cpu_ras");

    // Back-to-back reads from all three requesters
    push(0, 1'b0, 8'h01, 8'h00);
    push(1, 1'b0, 8'h02, 8'h00);
    push(2, 1'b0, 8'h03, 8'h00);
    wait_idle("b2b");

    // Reset one cycle after a CPU read was accepted
    push(1, 1'b0, 8'h10, 8'h00);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      #1;
      seen = xfer_last[1];
    end
    if (!seen) chk("timeout_rst_read", 32'd0, 32'd1);
    push(0, 1'b0, 8'h30, 8'h00);
    push(0, 1'b0, 8'h31, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    wait_idle("post_rst");

    // Randomized mix with address reuse to exercise read-after-write
    for (int b = 0; b < 60; b++) begin
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        push(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 15)), 8'($urandom));
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    wait_idle("random");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/vgacpu_sram_arbiter.md
# vgacpu_sram_arbiter

Shares the single-port `inferred_sram` between three requesters: the VGA scanout (read-only, highest priority), the CPU and the rasterizer (read/write). Sits in `vgacpu_top` between those units and the SRAM instance. It drives the SRAM's address, write-enable and write-data ports, and routes read data back to the owning requester. The datapath is fully pipelined: one access per cycle.

## Interface
- `D_WIDTH`, default 8: data width; must match the SRAM instance.
- `A_WIDTH`, default 8: address width; must match the SRAM instance.

- `clk`  in  1  system clock (50 MHz domain, `clk_50` at top).
- `rst`  in  1  asynchronous, active-high reset.
- `vga_req`  in  1  VGA read request.
- `vga_addr`  in  A_WIDTH  VGA read address.
- `vga_gnt`  out  1  VGA request accepted this cycle.
- `vga_rvalid`  out  1  VGA read data valid.
- `vga_rdata`  out  D_WIDTH  VGA read data.
- `cpu_req`, `ras_req`  in  1  request.
- `cpu_we`, `ras_we`  in  1  1 = write, 0 = read.
- `cpu_addr`, `ras_addr`  in  A_WIDTH  address.
- `cpu_wdata`, `ras_wdata`  in  D_WIDTH  write data.
- `cpu_gnt`, `ras_gnt`  out  1  request accepted this cycle.
- `cpu_rvalid`, `ras_rvalid`  out  1  read data valid.
- `cpu_rdata`, `ras_rdata`  out  D_WIDTH  read data.
- `sram_addr`  out  A_WIDTH  registered SRAM address.
- `sram_we`  out  1  registered SRAM write enable.
- `sram_wdata`  out  D_WIDTH  registered SRAM write data.
- `sram_rdata`  in  D_WIDTH  SRAM read data, valid one cycle after the address is presented.

## Operation
- **Handshake:** a requester holds `req`, `addr`, `we` and `wdata` stable until it sees `gnt`. A transfer occurs in a cycle with `req && gnt`.
- **Arbitration:** combinational within the cycle. At most one `gnt` is high per cycle.
  - VGA always wins when `vga_req` is high.
  - Otherwise, CPU and rasterizer are arbitrated per the configuration.
- **Stage 1 (issue register):** on a granted cycle, the winner's `addr`, `we` and `wdata` are registered onto the `sram_*` ports. The owner tag (`OWN_VGA`, `OWN_CPU`, `OWN_RAS`) is registered only for reads.
  - With no grant: `sram_we` = 0 and the tag is `OWN_NONE`. `sram_addr` and `sram_wdata` hold their values.
- **Stage 2 (return register):** the tag advances one stage. When the stage-2 tag matches a requester, that requester's `rvalid` is pulsed for one cycle and its `rdata` is loaded from `sram_rdata`. The other requesters' `rdata` values hold.
- **Writes:** never produce `rvalid`. A read issued in the cycle after a write to the same address returns the new data (SRAM write-first ordering is not relied upon, since the accesses land in different cycles).
- **Reset (async, `rst` high):**
  - `sram_addr`, `sram_wdata`, all `rdata` = 0.
  - `sram_we`, all `rvalid` = 0.
  - Both tags = `OWN_NONE`; round-robin pointer = CPU-next.
  - Reset mid-operation discards in-flight reads: no `rvalid` follows.
  - All `gnt` outputs are low while `rst` is high.
- **Simultaneous requests:** VGA > (CPU/rasterizer by policy). A losing requester stays pending with no loss of its request.

## Timing
- Grant latency 0: `gnt` is high in the same cycle as `req` if that requester wins.
- Read latency: the accept edge is edge N.
  - `sram_addr` valid after edge N.
  - `sram_rdata` valid after edge N+1.
  - `rvalid` and `rdata` valid after edge N+2, i.e. 2 cycles after the accepting edge.
- Write: `sram_we` is high for exactly the one cycle following the accept edge.
- Throughput: one access per cycle, in any mix of requesters.

## Configuration
- `VGACPU_SRAM_ARB_ROUND_ROBIN_EN` defined: CPU and rasterizer alternate. A 1-bit pointer flips to the other requester after each CPU or rasterizer grant; VGA grants leave it unchanged.
- Not defined: the CPU always beats the rasterizer, and the pointer register is not built.

## Structure
- `vgacpu_pkg` holds `typedef enum logic [1:0] owner_t {OWN_NONE, OWN_VGA, OWN_CPU, OWN_RAS}`, plus the `D_WIDTH` and `A_WIDTH` default constants shared with `inferred_sram`.
- One sub-module, `vgacpu_sram_arb_pick`: combinational priority/round-robin picker taking the three `req` bits and the pointer, returning one-hot grants. The pointer register stays in the parent.

## Test plan
- Reset: assert `rst` mid-read (CPU read of addr 0x10 accepted one cycle before) -> all outputs 0, no `cpu_rvalid` ever appears for that read.
- Single CPU path: CPU writes 0xA5 to 0x20, then reads 0x20 -> `sram_we` pulses 1 cycle; `cpu_rvalid` 2 cycles after the read grant with `cpu_rdata` = 0xA5.
- VGA priority: VGA, CPU and rasterizer all request every cycle for 4 cycles -> `vga_gnt` in all 4 cycles, `cpu_gnt` = `ras_gnt` = 0; CPU and rasterizer are granted after VGA drops.
- Round robin (macro on): CPU and rasterizer request continuously -> grants alternate CPU, RAS, CPU, RAS. With the macro off -> CPU only.
- Back-to-back reads: VGA reads 0x01, CPU reads 0x02, rasterizer reads 0x03 on consecutive cycles -> each `rvalid` fires once, in the same order, 2 cycles after its grant, with the data preloaded at each address and no cross-routing.
